rf_write_arbiter: RTL and testbench

Shares the single register-file write port (WRITE_ENABLE / ADDRESS_3 / WRITE_DATA) between two producers: the in-order pipeline writeback (requester 0) and the multi-cycle unit such as the divider or load return path (requester 1). Requester 0 has fixed priority, and a starvation counter forces a grant to requester 1 after a bounded wait. The write-port outputs are registered, so the register file sees one clean write per cycle. The file's combinational write-to-read forwarding works unchanged.

---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_starve_counter.sv | 30 +++
 rtl/rf_write_arbiter.sv | 106 ++++++++++
 tb/tb_rf_write_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_pkg;

  // Arbiter modes: NORMAL gives the pipeline priority, FORCE serves the multi-cycle unit.
  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_t;

  // Requester IDs as reported on grant_id.
  localparam logic REQ_PIPE = 1'b0;
  localparam logic REQ_MCU  = 1'b1;

  // Register x0 is hardwired to zero; writes to it are accepted but suppressed.
  localparam int X0_ADDR = 0;

endpackage

// File: rtl/rf_starve_counter.sv
// Saturating count of consecutive cycles the multi-cycle unit has lost arbitration.
module rf_starve_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  logic [3:0] count;

  // Clear has priority over increment; the count never wraps past MAX_WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 4'd0;
    end else if (clr) begin
      count <= 4'd0;
    end else if (inc && (count != MAX_CNT)) begin
      count <= count + 4'd1;
    end
  end

  // High when the increment happening this cycle lands the count on MAX_WAIT.
  assign at_max = inc && !clr && (count >= (MAX_CNT - 4'd1));

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between the pipeline writeback
// (fixed priority) and the multi-cycle unit (starvation-protected), with a
// registered write stage so the register file sees one clean write per cycle.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADD_WIDTH = 5,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [ADD_WIDTH-1:0] req0_address,
  input  logic [WIDTH-1:0]     req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ADD_WIDTH-1:0] req1_address,
  input  logic [WIDTH-1:0]     req1_data,
  output logic                 req1_ready,
  output logic                 write_enable,
  output logic [ADD_WIDTH-1:0] address_3,
  output logic [WIDTH-1:0]     write_data,
  output logic                 grant_id,
  output logic                 force_active
);

  localparam logic [ADD_WIDTH-1:0] ZERO_REG = ADD_WIDTH'(X0_ADDR);

  arb_state_t state;
  arb_state_t next_state;
  logic       accept0;
  logic       accept1;
  logic       cnt_inc;
  logic       cnt_clr;
  logic       at_max;

  // Ready depends only on the mode and the pipeline's valid, so it is safe to use combinationally upstream.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b1;
    if (state == ARB_NORMAL) begin
      req0_ready = 1'b1;
      req1_ready = ~req0_valid;
    end
  end

  assign accept0 = req0_valid & req0_ready;
  assign accept1 = req1_valid & req1_ready & ~accept0;
  assign cnt_inc = req1_valid & ~accept1;
  assign cnt_clr = ~cnt_inc;

  rf_starve_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .at_max(at_max)
  );

  // Enter FORCE when the unit has lost MAX_WAIT times in a row; leave on its accept or if it withdraws.
  always_comb begin
    next_state = state;
    case (state)
      ARB_NORMAL: if (at_max) next_state = ARB_FORCE;
      ARB_FORCE:  if (accept1 || !req1_valid) next_state = ARB_NORMAL;
      default:    next_state = ARB_NORMAL;
    endcase
  end

  // Mode register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_NORMAL;
    end else begin
      state <= next_state;
    end
  end

  // Write-port register: an accept lands one cycle later; x0 writes update address/ID but never strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_enable <= 1'b0;
      address_3    <= '0;
      write_data   <= '0;
      grant_id     <= REQ_PIPE;
    end else if (accept0) begin
      write_enable <= (req0_address != ZERO_REG);
      address_3    <= req0_address;
      write_data   <= req0_data;
      grant_id     <= REQ_PIPE;
    end else if (accept1) begin
      write_enable <= (req1_address != ZERO_REG);
      address_3    <= req1_address;
      write_data   <= req1_data;
      grant_id     <= REQ_MCU;
    end else begin
      write_enable <= 1'b0;
    end
  end

  assign force_active = (state == ARB_FORCE);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus a randomized
// run, all compared against a cycle-level behavioural model of the arbitration rules.
module tb_rf_write_arbiter;

  localparam int WIDTH     = 32;
  localparam int ADD_WIDTH = 5;
  localparam int MAX_WAIT  = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 req0_valid = 1'b0;
  logic [ADD_WIDTH-1:0] req0_address = '0;
  logic [WIDTH-1:0]     req0_data = '0;
  logic                 req0_ready;
  logic                 req1_valid = 1'b0;
  logic [ADD_WIDTH-1:0] req1_address = '0;
  logic [WIDTH-1:0]     req1_data = '0;
  logic                 req1_ready;
  logic                 write_enable;
  logic [ADD_WIDTH-1:0] address_3;
  logic [WIDTH-1:0]     write_data;
  logic                 grant_id;
  logic                 force_active;

  int checks = 0;
  int failures = 0;

  // Model state: mode, consecutive losses of requester 1, and the expected write port.
  bit                   m_force = 1'b0;
  int                   m_lose = 0;
  logic                 m_we = 1'b0;
  logic [ADD_WIDTH-1:0] m_addr = '0;
  logic [WIDTH-1:0]     m_data = '0;
  logic                 m_gid = 1'b0;
  bit                   m_data_known = 1'b1;

  always #5 clk = ~clk;

  rf_write_arbiter #(
    .WIDTH(WIDTH), .ADD_WIDTH(ADD_WIDTH), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_address(req0_address), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_address(req1_address), .req1_data(req1_data), .req1_ready(req1_ready),
    .write_enable(write_enable), .address_3(address_3), .write_data(write_data),
    .grant_id(grant_id), .force_active(force_active)
  );

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit r0, r1, a0, a1;
    if (reset) begin
      m_force = 0; m_lose = 0; m_we = 0; m_addr = '0; m_data = '0; m_gid = 0; m_data_known = 1;
      return;
    end
    r0 = !m_force;
    r1 = m_force || !req0_valid;
    a0 = req0_valid && r0;
    a1 = req1_valid && r1 && !a0;
    if (a0) begin
      m_we = (req0_address != 0); m_addr = req0_address; m_data = req0_data; m_gid = 0;
      m_data_known = (req0_address != 0);
    end else if (a1) begin
      m_we = (req1_address != 0); m_addr = req1_address; m_data = req1_data; m_gid = 1;
      m_data_known = (req1_address != 0);
    end else begin
      m_we = 0;
    end
    if (m_force) begin
      if (a1 || !req1_valid) begin m_force = 0; m_lose = 0; end
    end else if (req1_valid && !a1) begin
      m_lose++;
      if (m_lose >= MAX_WAIT) m_force = 1;
    end else begin
      m_lose = 0;
    end
  endtask

  function automatic logic [1:0] exp_ready();
    return {!m_force, m_force || !req0_valid};
  endfunction

  function automatic logic [39:0] obs_port();
    return {write_enable, address_3, (m_data_known ? write_data : 32'h0), grant_id, force_active};
  endfunction

  function automatic logic [39:0] exp_port();
    return {m_we, m_addr, (m_data_known ? m_data : 32'h0), m_gid, logic'(m_force)};
  endfunction

  // Drive inputs just after a rising edge and let combinational ready settle.
  task automatic drive(input logic v0, input logic [ADD_WIDTH-1:0] a0, input logic [WIDTH-1:0] d0,
                       input logic v1, input logic [ADD_WIDTH-1:0] a1, input logic [WIDTH-1:0] d1);
    req0_valid = v0; req0_address = a0; req0_data = d0;
    req1_valid = v1; req1_address = a1; req1_data = d1;
    #1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, '0, '0, 0, '0, '0);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 5'd5, 32'h55, 1, 5'd6, 32'h66);
    tick();
    tick();
    checks++;
    if (obs_port() !== 40'h0) begin
      failures++; $display("[TB] FAIL reset_outputs got %h want %h", obs_port(), 40'h0);
    end
    reset = 1'b0;
    drive(1, 5'd5, 32'h55, 1, 5'd6, 32'h66);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++; $display("[TB] FAIL reset_ready got %b want %b", {req0_ready, req1_ready}, 2'b10);
    end
    drive(0, '0, '0, 0, '0, '0);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b11) begin
      failures++; $display("[TB] FAIL reset_ready_idle got %b want %b", {req0_ready, req1_ready}, 2'b11);
    end
  endtask

  task automatic test_req0_stream();
    logic [31:0] dat [3] = '{32'hA, 32'hB, 32'hC};
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(i + 1), dat[i], 0, '0, '0);
      checks++;
      if (req0_ready !== 1'b1) begin
        failures++; $display("[TB] FAIL stream_ready[%0d] got %b want 1", i, req0_ready);
      end
      tick();
      checks++;
      if ({write_enable, address_3, write_data, grant_id} !== {1'b1, 5'(i + 1), dat[i], 1'b0}) begin
        failures++;
        $display("[TB] FAIL stream_write[%0d] got we=%b a=%0d d=%h g=%b want we=1 a=%0d d=%h g=0",
                 i, write_enable, address_3, write_data, grant_id, i + 1, dat[i]);
      end
    end
    idle();
    checks++;
    if (obs_port() !== exp_port()) begin
      failures++; $display("[TB] FAIL stream_idle got %h want %h", obs_port(), exp_port());
    end
  endtask

  task automatic test_req1_alone();
    drive(0, '0, '0, 1, 5'd7, 32'hDEAD_BEEF);
    checks++;
    if (req1_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL req1_alone_ready got %b want 1", req1_ready);
    end
    tick();
    checks++;
    if ({write_enable, address_3, write_data, grant_id} !== {1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1}) begin
      failures++;
      $display("[TB] FAIL req1_alone_write got we=%b a=%0d d=%h g=%b want we=1 a=7 d=deadbeef g=1",
               write_enable, address_3, write_data, grant_id);
    end
    idle();
  endtask

  task automatic test_starvation();
    int waited = 0;
    int force_seen = 0;
    logic [ADD_WIDTH-1:0] a0 = 5'd10;
    bool_loop: for (int c = 1; c <= 3 * MAX_WAIT; c++) begin
      logic got1;
      logic got0;
      drive(1, a0, {27'h0, a0}, 1, 5'd9, 32'h0000_0999);
      checks++;
      if ({req0_ready, req1_ready} !== exp_ready()) begin
        failures++; $display("[TB] FAIL starve_ready[%0d] got %b want %b", c, {req0_ready, req1_ready}, exp_ready());
      end
      got1 = req1_ready;
      got0 = req0_ready;
      tick();
      checks++;
      if (obs_port() !== exp_port()) begin
        failures++; $display("[TB] FAIL starve_port[%0d] got %h want %h", c, obs_port(), exp_port());
      end
      if (force_active && force_seen == 0) force_seen = c;
      if (got0) a0 = a0 + 5'd1;
      if (got1) begin waited = c; break; end
    end
    checks++;
    if (force_seen != MAX_WAIT) begin
      failures++; $display("[TB] FAIL starve_force_entry got %0d want %0d", force_seen, MAX_WAIT);
    end
    checks++;
    if (waited != MAX_WAIT + 1) begin
      failures++; $display("[TB] FAIL starve_wait got %0d want %0d", waited, MAX_WAIT + 1);
    end
    checks++;
    if ({write_enable, address_3, grant_id, force_active} !== {1'b1, 5'd9, 1'b1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL starve_write got we=%b a=%0d g=%b f=%b want we=1 a=9 g=1 f=0",
               write_enable, address_3, grant_id, force_active);
    end
    idle();
  endtask

  task automatic test_x0();
    drive(1, 5'd0, 32'hFFFF_FFFF, 0, '0, '0);
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL x0_ready got %b want 1", req0_ready);
    end
    tick();
    checks++;
    if ({write_enable, address_3, grant_id} !== {1'b0, 5'd0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL x0_write got we=%b a=%0d g=%b want we=0 a=0 g=0", write_enable, address_3, grant_id);
    end
    idle();
  endtask

  task automatic test_force_drop();
    int losses = 0;
    for (int c = 0; c < MAX_WAIT; c++) begin
      drive(1, 5'd12, 32'h12, 1, 5'd13, 32'h13);
      tick();
    end
    checks++;
    if (force_active !== 1'b1) begin
      failures++; $display("[TB] FAIL drop_enter got %b want 1", force_active);
    end
    drive(1, 5'd12, 32'h12, 0, 5'd13, 32'h13);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      failures++; $display("[TB] FAIL drop_ready got %b want 01", {req0_ready, req1_ready});
    end
    tick();
    checks++;
    if ({write_enable, force_active} !== 2'b00) begin
      failures++; $display("[TB] FAIL drop_exit got we=%b f=%b want we=0 f=0", write_enable, force_active);
    end
    // A fresh request must again lose the full MAX_WAIT cycles, proving the count cleared.
    for (int c = 1; c <= 3 * MAX_WAIT; c++) begin
      drive(1, 5'd12, 32'h12, 1, 5'd14, 32'h14);
      tick();
      checks++;
      if (obs_port() !== exp_port()) begin
        failures++; $display("[TB] FAIL drop_port[%0d] got %h want %h", c, obs_port(), exp_port());
      end
      if (force_active) begin losses = c; break; end
    end
    checks++;
    if (losses != MAX_WAIT) begin
      failures++; $display("[TB] FAIL drop_recount got %0d want %0d", losses, MAX_WAIT);
    end
    drive(1, 5'd12, 32'h12, 1, 5'd14, 32'h14);
    tick();
    idle();
  endtask

  task automatic test_reset_during_accept();
    drive(1, 5'd3, 32'h33, 0, '0, '0);
    tick();
    reset = 1'b1;
    drive(1, 5'd5, 32'h5555, 0, '0, '0);
    tick();
    reset = 1'b0;
    checks++;
    if (obs_port() !== 40'h0) begin
      failures++; $display("[TB] FAIL reset_accept got %h want %h", obs_port(), 40'h0);
    end
    idle();
    checks++;
    if ({write_enable, address_3} !== {1'b0, 5'd0}) begin
      failures++; $display("[TB] FAIL reset_accept_after got we=%b a=%0d want we=0 a=0", write_enable, address_3);
    end
  endtask

  task automatic test_random();
    bit p0 = 0, p1 = 0;
    logic [ADD_WIDTH-1:0] a0 = '0, a1 = '0;
    logic [WIDTH-1:0] d0 = '0, d1 = '0;
    for (int c = 0; c < 400; c++) begin
      logic [1:0] er;
      bit acc0, acc1;
      if (!p0 && ($urandom_range(0, 1) == 1)) begin
        p0 = 1; a0 = 5'($urandom); d0 = $urandom;
      end
      if (!p1 && ($urandom_range(0, 2) == 0)) begin
        p1 = 1; a1 = 5'($urandom); d1 = $urandom;
      end
      reset = ($urandom_range(0, 59) == 0);
      drive(p0, a0, d0, p1, a1, d1);
      er = exp_ready();
      checks++;
      if ({req0_ready, req1_ready} !== er) begin
        failures++; $display("[TB] FAIL rand_ready[%0d] got %b want %b", c, {req0_ready, req1_ready}, er);
      end
      acc0 = !reset && p0 && er[1];
      acc1 = !reset && p1 && er[0] && !acc0;
      tick();
      checks++;
      if (obs_port() !== exp_port()) begin
        failures++; $display("[TB] FAIL rand_port[%0d] got %h want %h", c, obs_port(), exp_port());
      end
      if (acc0) p0 = 0;
      if (acc1) p1 = 0;
    end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_req0_stream();
    test_req1_alone();
    test_starvation();
    test_x0();
    test_force_drop();
    test_reset_during_accept();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
